// File: rtl/led_tick_ctrl.sv
// Step-enable generator for the LED chaser: debounced faster/slower buttons pick one of
// eight tick periods, and a debounced pause switch freezes the prescaler.
module led_tick_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned BASE_DIV   = 65536,
    parameter int unsigned INIT_LEVEL = 3
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iBTN_UP,
    input  logic       iBTN_DN,
    input  logic       iPAUSE,
    output logic       oTICK,
    output logic [2:0] oLEVEL,
    output logic       oPAUSED
);

    localparam int IDX_UP    = 0;
    localparam int IDX_DN    = 1;
    localparam int IDX_PAUSE = 2;

    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_db;
    logic [2:0]  r_db_d;
    logic [31:0] r_deb_cnt [3];
    logic [2:0]  r_level;
    logic [31:0] r_presc;

    logic        w_up_ev;
    logic        w_dn_ev;
    logic        w_paused;
    logic [2:0]  w_level_nxt;
    logic        w_lvl_chg;
    logic [31:0] w_period;
    logic [31:0] w_last;
    logic        w_tick;

    // Two-flop synchronizers feed independent stable-count debouncers; r_db_d gives edge detect.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= {iPAUSE, iBTN_DN, iBTN_UP};
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_CYCLES - 32'd1) begin
                    r_db[i]      <= ~r_db[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign w_up_ev  = r_db[IDX_UP] & ~r_db_d[IDX_UP];
    assign w_dn_ev  = r_db[IDX_DN] & ~r_db_d[IDX_DN];
    assign w_paused = r_db[IDX_PAUSE];

    always_comb begin
        w_level_nxt = r_level;
        if (w_up_ev && !w_dn_ev && r_level != 3'd7) begin
            w_level_nxt = r_level + 3'd1;
        end else if (w_dn_ev && !w_up_ev && r_level != 3'd0) begin
            w_level_nxt = r_level - 3'd1;
        end
    end

    // A saturated press is not a change, so it leaves the prescaler running.
    assign w_lvl_chg = (w_level_nxt != r_level);
    assign w_period  = 32'(BASE_DIV) << (3'd7 - r_level);
    assign w_last    = w_period - 32'd1;
    assign w_tick    = !w_paused && !w_lvl_chg && (r_presc == w_last);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_level <= 3'(INIT_LEVEL);
            r_presc <= '0;
        end else begin
            r_level <= w_level_nxt;
            if (w_lvl_chg) begin
                r_presc <= '0;
            end else if (w_paused) begin
                r_presc <= r_presc;
            end else if (r_presc == w_last) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 32'd1;
            end
        end
    end

    assign oTICK   = w_tick;
    assign oLEVEL  = r_level;
    assign oPAUSED = w_paused;

endmodule

// File: tb/tb_led_tick_ctrl.sv
// Directed bench for led_tick_ctrl with DEB_CYCLES=4, BASE_DIV=2, INIT_LEVEL=3.
// Outputs are sampled 1 ns after each rising edge; inputs change at the same point.
module tb_led_tick_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic       pause = 1'b0;
    logic       tick;
    logic [2:0] level;
    logic       paused;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    led_tick_ctrl #(
        .DEB_CYCLES(4),
        .BASE_DIV  (2),
        .INIT_LEVEL(3)
    ) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .iBTN_UP(btn_up),
        .iBTN_DN(btn_dn),
        .iPAUSE (pause),
        .oTICK  (tick),
        .oLEVEL (level),
        .oPAUSED(paused)
    );

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges advanced until oTICK is seen high; -1 when the budget runs out.
    task automatic wait_tick(input int max_cyc, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (tick !== 1'b1 && n < max_cyc);
        if (tick !== 1'b1) n = -1;
    endtask

    task automatic do_reset();
        btn_up = 1'b0;
        btn_dn = 1'b0;
        pause  = 1'b0;
        rst_n  = 1'b0;
        cycles(3);
        rst_n  = 1'b1;
    endtask

    // Held 10 clocks (level moves on clock 7), then 10 clocks released.
    task automatic press(input bit up, input bit dn);
        btn_up = up;
        btn_dn = dn;
        cycles(10);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        cycles(10);
    endtask

    // Level 3 -> P=32: prescaler 0..31, oTICK seen after 31 edges (consumed on the 32nd).
    task automatic test_reset();
        int n;
        do_reset();
        n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %0b expected 0", tick); end
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL reset_level: got %0d expected 3", level); end
        n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL reset_paused: got %0b expected 0", paused); end
        wait_tick(100, n);
        n_cmp++; if (n != 31) begin n_err++; $display("FAIL reset_first_tick: got %0d expected 31", n); end
        wait_tick(100, n);
        n_cmp++; if (n != 32) begin n_err++; $display("FAIL reset_tick_spacing: got %0d expected 32", n); end
        // Reset lands while oTICK is high; it must drop without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL midreset_tick: got %0b expected 0", tick); end
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL midreset_level: got %0d expected 3", level); end
        cycles(2);
        rst_n = 1'b1;
        wait_tick(100, n);
        n_cmp++; if (n != 31) begin n_err++; $display("FAIL midreset_first_tick: got %0d expected 31", n); end
    endtask

    task automatic test_debounce();
        int n;
        do_reset();
        btn_up = 1'b1;
        cycles(3);
        btn_up = 1'b0;
        cycles(12);
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL glitch_level: got %0d expected 3", level); end
        // 2 sync clocks + 4 stable samples -> debounced on clock 6, level on clock 7.
        btn_up = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (level === 3'd3 && n < 20);
        n_cmp++; if (n != 7) begin n_err++; $display("FAIL press_latency: got %0d expected 7", n); end
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL press_level: got %0d expected 4", level); end
        // Prescaler restarts at 0 with P=16.
        wait_tick(100, n);
        n_cmp++; if (n != 15) begin n_err++; $display("FAIL newrate_first_tick: got %0d expected 15", n); end
        btn_up = 1'b0;
        cycles(12);
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL hold_release_level: got %0d expected 4", level); end
        wait_tick(100, n);
        wait_tick(100, n);
        n_cmp++; if (n != 16) begin n_err++; $display("FAIL level4_spacing: got %0d expected 16", n); end
    endtask

    task automatic test_saturation();
        int n;
        int exp_lvl;
        do_reset();
        exp_lvl = 3;
        for (int i = 0; i < 5; i++) begin
            press(1'b1, 1'b0);
            exp_lvl = (exp_lvl < 7) ? exp_lvl + 1 : 7;
            n_cmp++; if (level !== 3'(exp_lvl)) begin n_err++; $display("FAIL up_sat_%0d: got %0d expected %0d", i, level, exp_lvl); end
        end
        wait_tick(300, n);
        wait_tick(300, n);
        n_cmp++; if (n != 2) begin n_err++; $display("FAIL level7_spacing: got %0d expected 2", n); end
        for (int i = 0; i < 9; i++) begin
            press(1'b0, 1'b1);
            exp_lvl = (exp_lvl > 0) ? exp_lvl - 1 : 0;
            n_cmp++; if (level !== 3'(exp_lvl)) begin n_err++; $display("FAIL dn_sat_%0d: got %0d expected %0d", i, level, exp_lvl); end
        end
        wait_tick(300, n);
        wait_tick(300, n);
        n_cmp++; if (n != 256) begin n_err++; $display("FAIL level0_spacing: got %0d expected 256", n); end
    endtask

    // Both events cancel; prescaler keeps counting, so the next tick stays 32 after the last.
    task automatic test_simultaneous();
        int n;
        do_reset();
        wait_tick(100, n);
        btn_up = 1'b1;
        btn_dn = 1'b1;
        cycles(10);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        cycles(10);
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL simul_level: got %0d expected 3", level); end
        wait_tick(100, n);
        n_cmp++; if (n != 12) begin n_err++; $display("FAIL simul_presc_kept: got %0d expected 12", n); end
    endtask

    task automatic test_pause();
        int n;
        int ticks;
        do_reset();
        wait_tick(100, n);
        cycles(15);
        // Prescaler is at 14 now; it advances 6 more clocks until oPAUSED rises and freezes at 20.
        pause = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (paused !== 1'b1 && n < 20);
        n_cmp++; if (n != 6) begin n_err++; $display("FAIL pause_rise_latency: got %0d expected 6", n); end
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            if (tick === 1'b1) ticks++;
        end
        n_cmp++; if (ticks != 0) begin n_err++; $display("FAIL paused_ticks: got %0d expected 0", ticks); end
        pause = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (paused !== 1'b0 && n < 20);
        n_cmp++; if (n != 6) begin n_err++; $display("FAIL pause_fall_latency: got %0d expected 6", n); end
        wait_tick(100, n);
        n_cmp++; if (n != 11) begin n_err++; $display("FAIL resume_tick: got %0d expected 11", n); end
        // Level change while paused zeroes the held prescaler; resume then needs 15 edges at P=16.
        pause = 1'b1;
        cycles(10);
        press(1'b1, 1'b0);
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL paused_level: got %0d expected 4", level); end
        pause = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (paused !== 1'b0 && n < 20);
        wait_tick(100, n);
        n_cmp++; if (n != 15) begin n_err++; $display("FAIL paused_lvl_resume: got %0d expected 15", n); end
    endtask

    // Pin set at prescaler 24 -> level update on the edge leaving prescaler 30.
    task automatic test_level_change();
        int n;
        int ticks;
        do_reset();
        wait_tick(100, n);
        cycles(25);
        btn_up = 1'b1;
        n = 0;
        ticks = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (tick === 1'b1) ticks++;
        end while (level === 3'd3 && n < 20);
        n_cmp++; if (n != 7) begin n_err++; $display("FAIL midperiod_latency: got %0d expected 7", n); end
        n_cmp++; if (ticks != 0) begin n_err++; $display("FAIL midperiod_old_tick: got %0d expected 0", ticks); end
        wait_tick(100, n);
        n_cmp++; if (n != 15) begin n_err++; $display("FAIL midperiod_new_tick: got %0d expected 15", n); end
        btn_up = 1'b0;
        cycles(10);
    endtask

    task automatic test_reset_dirty();
        do_reset();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        pause = 1'b1;
        cycles(10);
        n_cmp++; if (level !== 3'd5) begin n_err++; $display("FAIL dirty_pre_level: got %0d expected 5", level); end
        n_cmp++; if (paused !== 1'b1) begin n_err++; $display("FAIL dirty_pre_paused: got %0b expected 1", paused); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL dirty_reset_level: got %0d expected 3", level); end
        n_cmp++; if (paused !== 1'b0) begin n_err++; $display("FAIL dirty_reset_paused: got %0b expected 0", paused); end
        n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL dirty_reset_tick: got %0b expected 0", tick); end
        pause = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_saturation();
        test_simultaneous();
        test_pause();
        test_level_change();
        test_reset_dirty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
